// File: rtl/audio_voice_engine.sv
// audio_voice_engine
// Time-multiplexed voice synthesiser. Each voice runs its own phase
// accumulator and produces a pulse, triangle, sawtooth or noise waveform,
// scaled by an unsigned volume. One voice is processed per clock. The voices
// are summed, saturated and presented as a left-justified signed sample
// through a valid/ready handshake.
//
// Ports
//   CLOCK_50    in   single clock
//   reset_n     in   asynchronous active-low reset
//   wr_en       in   register write strobe
//   wr_voice    in   target voice of the write
//   wr_field    in   0=phase_inc, 1=volume, 2=mode/duty, 3=control
//   wr_data     in   write data
//   out_ready   in   consumer accepts the presented sample
//   out_valid   out  out_sample holds a new sample
//   out_sample  out  signed mixed sample, left-justified in OUT_W bits
module audio_voice_engine #(
    parameter int NUM_VOICES = 4,
    parameter int AMP_W      = 16,
    parameter int PHASE_W    = 24,
    parameter int OUT_W      = 32,
    localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [VW-1:0]    wr_voice,
    input  logic [1:0]       wr_field,
    input  logic [31:0]      wr_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_sample
);

    // Sixteen full-scale contributions need AMP_W+4 bits; two spare bits of
    // headroom keep the sum well clear of wrap-around.
    localparam int ACC_W = AMP_W + 6;
    localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);
    localparam logic [AMP_W-1:0] POS_FULL = {1'b0, {(AMP_W-1){1'b1}}};
    localparam logic [AMP_W-1:0] NEG_FULL = -POS_FULL;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (AMP_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CALC,
        ST_LOAD
    } state_t;

    state_t state;
    logic [VW-1:0] cur_voice;
    logic signed [ACC_W-1:0] acc;

    logic [PHASE_W-1:0] phase_inc [NUM_VOICES];
    logic [PHASE_W-1:0] phase     [NUM_VOICES];
    logic [AMP_W-1:0]   vol       [NUM_VOICES];
    logic [1:0]         mode      [NUM_VOICES];
    logic [1:0]         duty      [NUM_VOICES];
    logic               enable    [NUM_VOICES];
    logic [14:0]        lfsr      [NUM_VOICES];

    logic [PHASE_W-1:0] cur_phase;
    logic [PHASE_W-1:0] phase_next;
    logic               phase_carry;
    logic [14:0]        lfsr_next;
    logic [2:0]         seg;
    logic [2:0]         pulse_lim;
    logic [AMP_W-1:0]   saw;
    logic [AMP_W-1:0]   tri_t;
    logic signed [AMP_W-1:0]   wave;
    logic signed [2*AMP_W:0]   prod;
    logic signed [ACC_W-1:0]   contrib;
    logic signed [ACC_W-1:0]   voice_contrib;
    logic [AMP_W-1:0]   sat_val;
    logic [OUT_W-1:0]   placed;
    logic               wr_ok;
    logic               calc_active;
    logic               unused_wr;

    assign unused_wr   = ^wr_data;
    assign wr_ok       = ({1'b0, wr_voice} < (VW+1)'(NUM_VOICES));
    assign calc_active = (state == ST_CALC);

    // Waveform generation for the voice currently selected by the sequencer.
    // Inverting the MSB of an unsigned ramp is the same as subtracting half
    // scale, which is how the sawtooth and rising triangle half are formed.
    always_comb begin
        cur_phase = phase[cur_voice];
        seg       = cur_phase[PHASE_W-1 -: 3];
        saw       = cur_phase[PHASE_W-1 -: AMP_W];
        tri_t     = cur_phase[PHASE_W-2 -: AMP_W];
        case (duty[cur_voice])
            2'd0:    pulse_lim = 3'd1;
            2'd1:    pulse_lim = 3'd2;
            2'd2:    pulse_lim = 3'd4;
            default: pulse_lim = 3'd6;
        endcase
        wave = '0;
        case (mode[cur_voice])
            2'd0:    wave = (seg < pulse_lim) ? POS_FULL : NEG_FULL;
            2'd1:    wave = cur_phase[PHASE_W-1] ? (POS_FULL - tri_t)
                                                 : {~tri_t[AMP_W-1], tri_t[AMP_W-2:0]};
            2'd2:    wave = {~saw[AMP_W-1], saw[AMP_W-2:0]};
            default: wave = lfsr[cur_voice][0] ? POS_FULL : NEG_FULL;
        endcase
    end

    // Volume scaling: signed wave times zero-extended volume, then floor shift.
    always_comb begin
        prod          = wave * $signed({1'b0, vol[cur_voice]});
        contrib       = ACC_W'(prod >>> AMP_W);
        voice_contrib = enable[cur_voice] ? contrib : '0;
        {phase_carry, phase_next} = {1'b0, cur_phase} + {1'b0, phase_inc[cur_voice]};
        lfsr_next     = {lfsr[cur_voice][13:0], lfsr[cur_voice][14] ^ lfsr[cur_voice][13]};
    end

    // Saturate the mix to AMP_W signed bits and left-justify it.
    always_comb begin
        if (acc > SAT_HI) begin
            sat_val = SAT_HI[AMP_W-1:0];
        end else if (acc < SAT_LO) begin
            sat_val = SAT_LO[AMP_W-1:0];
        end else begin
            sat_val = acc[AMP_W-1:0];
        end
        placed = '0;
        placed[OUT_W-1 -: AMP_W] = sat_val;
    end

    // Sequencer: WAIT holds the sample until it is taken, CALC walks the
    // voices one per cycle into the accumulator, LOAD publishes the result.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_WAIT;
            cur_voice  <= '0;
            acc        <= '0;
            out_valid  <= 1'b1;
            out_sample <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (out_valid && out_ready) begin
                        state     <= ST_CALC;
                        cur_voice <= '0;
                        acc       <= '0;
                        out_valid <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc <= acc + voice_contrib;
                    if (cur_voice == LAST_VOICE) begin
                        state <= ST_LOAD;
                    end else begin
                        cur_voice <= cur_voice + 1'b1;
                    end
                end
                ST_LOAD: begin
                    out_sample <= placed;
                    out_valid  <= 1'b1;
                    state      <= ST_WAIT;
                end
                default: begin
                    state     <= ST_WAIT;
                    out_valid <= 1'b1;
                end
            endcase
        end
    end

    // Voice registers. The phase/LFSR advance is assigned first so that a
    // phase-clear write in the same cycle wins. Other writes only change the
    // register, so the voice being computed still sees the old value and the
    // new one applies from the next sample.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_inc[v] <= '0;
                phase[v]     <= '0;
                vol[v]       <= '0;
                mode[v]      <= '0;
                duty[v]      <= '0;
                enable[v]    <= 1'b0;
                lfsr[v]      <= 15'h0001;
            end
        end else begin
            if (calc_active && enable[cur_voice]) begin
                phase[cur_voice] <= phase_next;
                if (phase_carry) begin
                    lfsr[cur_voice] <= lfsr_next;
                end
            end
            if (wr_en && wr_ok) begin
                case (wr_field)
                    2'd0: phase_inc[wr_voice] <= wr_data[PHASE_W-1:0];
                    2'd1: vol[wr_voice]       <= wr_data[AMP_W-1:0];
                    2'd2: begin
                        mode[wr_voice] <= wr_data[1:0];
                        duty[wr_voice] <= wr_data[3:2];
                    end
                    default: begin
                        enable[wr_voice] <= wr_data[0];
                        if (wr_data[1]) begin
                            phase[wr_voice] <= '0;
                            lfsr[wr_voice]  <= 15'h0001;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_voice_engine.sv
// tb_audio_voice_engine
// Self-checking bench for audio_voice_engine at default parameters. A
// behavioural model of the voices computes each sample when a transfer is
// issued; the expected value is queued and compared when it is delivered.
module tb_audio_voice_engine;

    localparam int NV = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [1:0]  wr_voice;
    logic [1:0]  wr_field;
    logic [31:0] wr_data;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_sample;

    int total = 0;
    int bad   = 0;
    logic        last_valid;
    logic [31:0] sb[$];
    logic [31:0] delivered[$];

    int m_phase[NV], m_inc[NV], m_vol[NV], m_mode[NV], m_duty[NV], m_en[NV], m_lfsr[NV];

    audio_voice_engine #(
        .NUM_VOICES(4), .AMP_W(16), .PHASE_W(24), .OUT_W(32)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_voice  (wr_voice),
        .wr_field  (wr_field),
        .wr_data   (wr_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sample(out_sample)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Hard stop in case something upstream never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0; m_inc[v] = 0; m_vol[v] = 0;
            m_mode[v] = 0; m_duty[v] = 0; m_en[v] = 0; m_lfsr[v] = 1;
        end
    endfunction

    function automatic void model_write(input int v, input int f, input logic [31:0] d);
        case (f)
            0: m_inc[v] = int'(d & 32'h00FF_FFFF);
            1: m_vol[v] = int'(d & 32'h0000_FFFF);
            2: begin
                m_mode[v] = int'(d & 32'h3);
                m_duty[v] = int'((d >> 2) & 32'h3);
            end
            default: begin
                m_en[v] = int'(d & 32'h1);
                if (d[1]) begin
                    m_phase[v] = 0;
                    m_lfsr[v]  = 1;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] model_compute();
        longint acc = 0;
        longint s;
        logic [15:0] s16;
        for (int v = 0; v < NV; v++) begin
            if (m_en[v] != 0) begin
                int p = m_phase[v];
                int seg = p >> 21;
                int lim;
                int w;
                int t;
                case (m_duty[v])
                    0: lim = 1;
                    1: lim = 2;
                    2: lim = 4;
                    default: lim = 6;
                endcase
                t = (p >> 7) & 65535;
                case (m_mode[v])
                    0: w = (seg < lim) ? 32767 : -32767;
                    1: w = (p >= 8388608) ? (32767 - t) : (t - 32768);
                    2: w = (p >> 8) - 32768;
                    default: w = ((m_lfsr[v] & 1) != 0) ? 32767 : -32767;
                endcase
                acc += (longint'(w) * longint'(m_vol[v])) >>> 16;
                p = p + m_inc[v];
                if (p >= 16777216) begin
                    int l = m_lfsr[v];
                    int fb = ((l >> 14) ^ (l >> 13)) & 1;
                    m_lfsr[v] = ((l << 1) | fb) & 32767;
                    p = p - 16777216;
                end
                m_phase[v] = p;
            end
        end
        s = (acc > 32767) ? 32767 : ((acc < -32768) ? -32768 : acc);
        s16 = 16'(s);
        return {s16, 16'h0000};
    endfunction

    // One clock: drive at the falling edge; if a transfer will happen at the
    // next rising edge, score the presented sample and queue the next one.
    task automatic cycle_tick(input logic rdy);
        @(negedge CLOCK_50);
        wr_en      = 1'b0;
        out_ready  = rdy;
        last_valid = out_valid;
        if (out_valid === 1'b1 && rdy) begin
            if (sb.size() == 0) begin
                checkOutput("sb_depth", 32'(sb.size()), 32'd1);
            end else begin
                checkOutput("sample", out_sample, sb.pop_front());
            end
            delivered.push_back(out_sample);
            sb.push_back(model_compute());
        end
    endtask

    // Register write issued while no transfer can occur.
    task automatic applyStimulus(input int v, input int f, input logic [31:0] d);
        @(negedge CLOCK_50);
        out_ready = 1'b0;
        wr_en     = 1'b1;
        wr_voice  = 2'(v);
        wr_field  = 2'(f);
        wr_data   = d;
        model_write(v, f, d);
    endtask

    task automatic run_samples(input int n);
        int target = delivered.size() + n;
        int budget = n * 6 + 20;
        while (delivered.size() < target && budget > 0) begin
            cycle_tick(1'b1);
            budget--;
        end
        if (delivered.size() < target) begin
            checkOutput("run_timeout", 32'(delivered.size()), 32'(target));
        end
    endtask

    task automatic wait_for_wait();
        int budget = 20;
        cycle_tick(1'b0);
        while (last_valid !== 1'b1 && budget > 0) begin
            cycle_tick(1'b0);
            budget--;
        end
        if (last_valid !== 1'b1) begin
            checkOutput("wait_timeout", 32'(last_valid), 32'd1);
        end
    endtask

    task automatic reset_expect();
        model_reset();
        sb.delete();
        sb.push_back(32'h0);
        delivered.delete();
    endtask

    initial begin
        int cnt;
        int changes;
        logic [31:0] held;

        reset_n   = 1'b0;
        out_ready = 1'b0;
        wr_en     = 1'b0;
        wr_voice  = '0;
        wr_field  = '0;
        wr_data   = '0;
        last_valid = 1'b0;
        reset_expect();
        #12;
        checkOutput("rst_valid", 32'(out_valid), 32'd1);
        checkOutput("rst_sample", out_sample, 32'h0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        // Idle engine: silence, one valid cycle in six.
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle_tick(1'b1);
            if (last_valid === 1'b1) cnt++;
        end
        checkOutput("valid_rate", 32'(cnt), 32'd5);

        // Single pulse voice, duty 2.
        wait_for_wait();
        applyStimulus(0, 0, 32'h0010_0000);
        applyStimulus(0, 1, 32'h0000_FFFF);
        applyStimulus(0, 2, 32'h0000_0008);
        applyStimulus(0, 3, 32'h0000_0001);
        delivered.delete();
        run_samples(18);
        checkOutput("pulse_pos_first", delivered[1], 32'h7FFE_0000);
        checkOutput("pulse_pos_last", delivered[8], 32'h7FFE_0000);
        checkOutput("pulse_neg_first", delivered[9], 32'h8001_0000);
        checkOutput("pulse_neg_last", delivered[16], 32'h8001_0000);
        checkOutput("pulse_wrap", delivered[17], 32'h7FFE_0000);

        // Four aligned pulse voices saturate in both directions.
        wait_for_wait();
        for (int v = 1; v < NV; v++) begin
            applyStimulus(v, 0, 32'h0010_0000);
            applyStimulus(v, 1, 32'h0000_FFFF);
            applyStimulus(v, 2, 32'h0000_0008);
        end
        for (int v = 0; v < NV; v++) applyStimulus(v, 3, 32'h0000_0003);
        delivered.delete();
        run_samples(17);
        checkOutput("sat_pos_first", delivered[1], 32'h7FFF_0000);
        checkOutput("sat_pos_last", delivered[8], 32'h7FFF_0000);
        checkOutput("sat_neg_first", delivered[9], 32'h8000_0000);
        checkOutput("sat_neg_last", delivered[16], 32'h8000_0000);

        // Long stall: sample held, valid held; nothing skipped afterwards.
        run_samples(3);
        wait_for_wait();
        held = out_sample;
        changes = 0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cycle_tick(1'b0);
            if (out_sample !== held) changes++;
            if (last_valid !== 1'b1) cnt++;
        end
        checkOutput("hold_stable", 32'(changes), 32'd0);
        checkOutput("hold_valid", 32'(cnt), 32'd0);
        run_samples(10);

        // Phase clear written while voice0 is being processed.
        wait_for_wait();
        for (int v = 1; v < NV; v++) applyStimulus(v, 3, 32'h0000_0000);
        run_samples(3);
        cycle_tick(1'b1);
        applyStimulus(0, 3, 32'h0000_0003);
        delivered.delete();
        run_samples(9);
        checkOutput("clr_first", delivered[1], 32'h7FFE_0000);
        checkOutput("clr_eighth", delivered[8], 32'h7FFE_0000);

        // Noise voice stepping on every second sample.
        wait_for_wait();
        applyStimulus(0, 3, 32'h0000_0000);
        applyStimulus(1, 0, 32'h0080_0000);
        applyStimulus(1, 1, 32'h0000_FFFF);
        applyStimulus(1, 2, 32'h0000_0003);
        applyStimulus(1, 3, 32'h0000_0003);
        delivered.delete();
        run_samples(9);
        checkOutput("noise_1", delivered[1], 32'h7FFE_0000);
        checkOutput("noise_2", delivered[2], 32'h7FFE_0000);
        checkOutput("noise_3", delivered[3], 32'h8001_0000);
        checkOutput("noise_4", delivered[4], 32'h8001_0000);

        // Triangle and sawtooth mixed with the noise voice.
        wait_for_wait();
        applyStimulus(2, 0, 32'h000C_0000);
        applyStimulus(2, 1, 32'h0000_8000);
        applyStimulus(2, 2, 32'h0000_0001);
        applyStimulus(2, 3, 32'h0000_0003);
        applyStimulus(3, 0, 32'h0005_0000);
        applyStimulus(3, 1, 32'h0000_4000);
        applyStimulus(3, 2, 32'h0000_0002);
        applyStimulus(3, 3, 32'h0000_0003);
        run_samples(40);

        // Reset in the middle of CALC (voice index 2).
        wait_for_wait();
        cycle_tick(1'b1);
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd1);
        checkOutput("mid_rst_sample", out_sample, 32'h0);
        reset_expect();
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        run_samples(4);

        // Enabling without reprogramming shows cleared inc/vol/mode/duty/phase.
        wait_for_wait();
        for (int v = 0; v < NV; v++) applyStimulus(v, 3, 32'h0000_0001);
        run_samples(4);
        wait_for_wait();
        applyStimulus(0, 1, 32'h0000_FFFF);
        delivered.delete();
        run_samples(4);
        checkOutput("post_rst_pulse", delivered[1], 32'h7FFE_0000);
        checkOutput("post_rst_hold", delivered[3], 32'h7FFE_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
